// File: rtl/uart_fifo_bridge_pkg.sv
// Shared constants for the uart FIFO bridge: register map, STATUS/CTRL bit
// positions and the TX drain / RX fill FSM state types.
package uart_fifo_bridge_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   localparam int ST_RX_NE    = 0;
   localparam int ST_RX_FULL  = 1;
   localparam int ST_TX_EMPTY = 2;
   localparam int ST_TX_FULL  = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_RX_OVR   = 5;
   localparam int ST_RX_FERR  = 6;

   localparam int CTRL_RXNE_IE = 0;
   localparam int CTRL_TXE_IE  = 1;

   typedef enum logic {
      T_IDLE = 1'b0,
      T_WAIT = 1'b1
   } tx_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_CLR  = 1'b1
   } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with (DEPTH_LOG2+1)-bit circular pointers; the
// pointer MSB separates full from empty. Push while full is taken only with a pop.
module uart_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    mem_r [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_r;
   logic [DEPTH_LOG2:0] rd_ptr_r;
   logic                push_ok_s;
   logic                pop_ok_s;

   // Qualify requests: pop needs data, push needs a free slot or a simultaneous pop.
   always_comb begin
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
         rd_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= din;
      end
   end

   assign dout  = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                  (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
   assign count = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU-bus register front-end for the uart core with buffered TX and RX FIFOs.
// Define UART_FIFO_BRIDGE_IRQ_EN to build the CTRL register and the irq output.
module uart_fifo_bridge
   import uart_fifo_bridge_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [1:0]  bus_addr,
   input  logic [7:0]  bus_wdata,
   output logic [31:0] bus_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_avail,
   input  logic        rx_error,
   output logic        rx_ack,
   output logic        irq
);

   logic                wr_s, rd_s;
   logic                tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
   logic                rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
   logic [7:0]          tx_dout_s, rx_dout_s;
   logic [DEPTH_LOG2:0] tx_count_s, rx_count_s;
   logic [2:0]          sts_clr_s;
   logic                tx_ovf_set_s, rx_ovr_set_s, rx_ferr_set_s, rx_ack_nx_s;
   logic                tx_ovf_r, rx_ovr_r, rx_ferr_r;
   logic [31:0]         status_s, rdata_nx_s, rdata_r;
   logic [7:0]          ctrl_rd_s, tx_data_r;
   logic                tx_wr_r, rx_ack_r, irq_nx_s, irq_r;
   tx_state_t           tx_state_r, tx_state_nx_s;
   rx_state_t           rx_state_r, rx_state_nx_s;

   assign wr_s      = bus_sel & bus_we;
   assign rd_s      = bus_sel & ~bus_we;
   assign tx_push_s = wr_s & (bus_addr == ADDR_DATA);
   assign rx_pop_s  = rd_s & (bus_addr == ADDR_DATA) & ~rx_empty_s;
   assign sts_clr_s = (wr_s && (bus_addr == ADDR_STATUS)) ? bus_wdata[ST_RX_FERR:ST_TX_OVF] : 3'b000;
   // A write into a full FIFO only survives if the drain FSM frees a slot this cycle.
   assign tx_ovf_set_s = tx_push_s & tx_full_s & ~tx_pop_s;

   uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk(clk), .resetn(resetn), .push(tx_push_s), .pop(tx_pop_s), .din(bus_wdata),
      .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk(clk), .resetn(resetn), .push(rx_push_s), .pop(rx_pop_s), .din(rx_data),
      .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
   );

   // TX drain: hand one byte to an idle uart, then wait for it to report busy.
   always_comb begin
      tx_state_nx_s = tx_state_r;
      tx_pop_s      = 1'b0;
      case (tx_state_r)
         T_IDLE: begin
            if (!tx_empty_s && !tx_busy) begin
               tx_pop_s      = 1'b1;
               tx_state_nx_s = T_WAIT;
            end else begin
               tx_state_nx_s = T_IDLE;
            end
         end
         T_WAIT: begin
            if (tx_busy) begin
               tx_state_nx_s = T_IDLE;
            end else begin
               tx_state_nx_s = T_WAIT;
            end
         end
         default: tx_state_nx_s = T_IDLE;
      endcase
   end

   // RX fill: accept one byte per rx_avail, then skip a cycle while rx_avail drops.
   always_comb begin
      rx_state_nx_s = rx_state_r;
      rx_push_s     = 1'b0;
      rx_ovr_set_s  = 1'b0;
      rx_ferr_set_s = 1'b0;
      rx_ack_nx_s   = 1'b0;
      case (rx_state_r)
         R_IDLE: begin
            if (rx_avail) begin
               rx_ack_nx_s   = 1'b1;
               rx_state_nx_s = R_CLR;
               if (rx_error) begin
                  rx_ferr_set_s = 1'b1;
               end else if (rx_full_s && !rx_pop_s) begin
                  rx_ovr_set_s = 1'b1;
               end else begin
                  rx_push_s = 1'b1;
               end
            end else begin
               rx_state_nx_s = R_IDLE;
            end
         end
         R_CLR:   rx_state_nx_s = R_IDLE;
         default: rx_state_nx_s = R_IDLE;
      endcase
   end

   // FSM state and uart handshake outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_state_r <= T_IDLE;
         rx_state_r <= R_IDLE;
         tx_wr_r    <= 1'b0;
         tx_data_r  <= 8'h00;
         rx_ack_r   <= 1'b0;
      end else begin
         tx_state_r <= tx_state_nx_s;
         rx_state_r <= rx_state_nx_s;
         tx_wr_r    <= tx_pop_s;
         rx_ack_r   <= rx_ack_nx_s;
         if (tx_pop_s) begin
            tx_data_r <= tx_dout_s;
         end
      end
   end

   // Sticky error flags; a new event wins over a same-cycle write-1-to-clear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_ovf_r  <= 1'b0;
         rx_ovr_r  <= 1'b0;
         rx_ferr_r <= 1'b0;
      end else begin
         tx_ovf_r  <= tx_ovf_set_s  | (tx_ovf_r  & ~sts_clr_s[0]);
         rx_ovr_r  <= rx_ovr_set_s  | (rx_ovr_r  & ~sts_clr_s[1]);
         rx_ferr_r <= rx_ferr_set_s | (rx_ferr_r & ~sts_clr_s[2]);
      end
   end

`ifdef UART_FIFO_BRIDGE_IRQ_EN
   logic [1:0] ctrl_r;

   // Interrupt-enable register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ctrl_r <= 2'b00;
      end else if (wr_s && (bus_addr == ADDR_CTRL)) begin
         ctrl_r <= bus_wdata[1:0];
      end
   end

   assign ctrl_rd_s = {6'b000000, ctrl_r};
   assign irq_nx_s  = (ctrl_r[CTRL_RXNE_IE] & ~rx_empty_s) |
                      (ctrl_r[CTRL_TXE_IE] & tx_empty_s & (tx_state_r == T_IDLE) & ~tx_busy);
`else
   assign ctrl_rd_s = 8'h00;
   assign irq_nx_s  = 1'b0;
`endif

   assign status_s = {8'h00, 8'(tx_count_s), 8'(rx_count_s), 1'b0, rx_ferr_r, rx_ovr_r, tx_ovf_r,
                      tx_full_s, tx_empty_s, rx_full_s, ~rx_empty_s};

   // Read-data mux; the DATA read shows the pre-pop head.
   always_comb begin
      rdata_nx_s = 32'h0000_0000;
      if (rd_s) begin
         case (bus_addr)
            ADDR_DATA:   rdata_nx_s = rx_empty_s ? 32'h0000_0000 : {23'h000000, 1'b1, rx_dout_s};
            ADDR_STATUS: rdata_nx_s = status_s;
            ADDR_CTRL:   rdata_nx_s = {24'h000000, ctrl_rd_s};
            default:     rdata_nx_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_nx_s = 32'h0000_0000;
      end
   end

   // Registered bus read data and interrupt.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_r <= 32'h0000_0000;
         irq_r   <= 1'b0;
      end else begin
         rdata_r <= rdata_nx_s;
         irq_r   <= irq_nx_s;
      end
   end

   assign bus_rdata = rdata_r;
   assign tx_data   = tx_data_r;
   assign tx_wr     = tx_wr_r;
   assign rx_ack    = rx_ack_r;
   assign irq       = irq_r;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed plus randomized bench for uart_fifo_bridge with a uart model and a
// queue-based reference of the FIFO contents and sticky flags.
module tb_uart_fifo_bridge;
   import uart_fifo_bridge_pkg::*;

   localparam int BUSY_CYC = 160;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        bus_sel = 1'b0, bus_we = 1'b0;
   logic [1:0]  bus_addr = 2'd0;
   logic [7:0]  bus_wdata = 8'h00;
   logic [31:0] bus_rdata;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_busy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_avail = 1'b0, rx_error = 1'b0;
   logic        rx_ack;
   logic        irq;

   int tests_run = 0;
   int fail_cnt  = 0;

   logic [7:0] sent_q[$];
   int         busy_cnt = 0;
   logic       hold_busy = 1'b0;
   int         wr_while_busy = 0;
   int         tx_wr_cnt = 0;
   int         ack_cnt = 0;

   uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .resetn(resetn), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .tx_data(tx_data), .tx_wr(tx_wr),
      .tx_busy(tx_busy), .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error),
      .rx_ack(rx_ack), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // uart model: samples DUT outputs and drives its inputs on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_wr) begin
            tx_wr_cnt++;
            if (tx_busy) wr_while_busy++;
            sent_q.push_back(tx_data);
            busy_cnt = BUSY_CYC;
         end else if (busy_cnt != 0) begin
            busy_cnt--;
         end
         tx_busy = hold_busy | (busy_cnt != 0);
         if (rx_ack) begin
            ack_cnt++;
            rx_avail = 1'b0;
            rx_error = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_sel = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
      @(negedge clk);
      bus_sel = 1'b0;
      d = bus_rdata;
   endtask

   task automatic rx_present(input logic [7:0] b, input logic e);
      int n;
      @(negedge clk);
      rx_data = b; rx_error = e; rx_avail = 1'b1;
      n = 0;
      while (rx_avail && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rx_handshake", {31'd0, rx_avail}, 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_sent(input int n, input int budget);
      int c;
      c = 0;
      while (sent_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("tx_sent_count", sent_q.size(), n);
   endtask

   task automatic wait_uart_idle();
      int c;
      c = 0;
      while (tx_busy && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("uart_idle", {31'd0, tx_busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  b;
      logic        e;
      int          acks0;
      logic [7:0]  rx_m[$];
      logic [7:0]  tx_exp[$];
      int          rand_tx;
      logic        ferr_m;
      logic [31:0] exp_v;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
      check("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", bus_rdata, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      resetn = 1'b1;
      bus_read(ADDR_STATUS, rd);
      check("rst_status", rd, 32'h0000_0004);
      bus_read(ADDR_CTRL, rd);
      check("rst_ctrl", rd, 32'h0000_0000);

      // 1: three bytes drained in order, never on a busy uart
      bus_write(ADDR_DATA, 8'h41);
      bus_write(ADDR_DATA, 8'h42);
      bus_write(ADDR_DATA, 8'h43);
      wait_sent(3, 1000);
      for (int i = 0; i < 3; i++) begin
         check("t1_order", (sent_q.size() > 0) ? {24'd0, sent_q.pop_front()} : 32'hFFFF_FFFF, 32'h41 + i);
      end
      check("t1_wr_pulses", tx_wr_cnt, 3);
      check("t1_wr_busy", wr_while_busy, 0);
      wait_uart_idle();

      // 2: overfill TX while the uart is held busy
      hold_busy = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 17; i++) bus_write(ADDR_DATA, 8'(8'h10 + i));
      bus_read(ADDR_STATUS, rd);
      check("t2_status_full_ovf", rd, 32'h0010_0018);
      bus_write(ADDR_STATUS, 8'h10);
      bus_read(ADDR_STATUS, rd);
      check("t2_status_w1c", rd, 32'h0010_0008);
      hold_busy = 1'b0;
      wait_sent(16, 16 * (BUSY_CYC + 20));
      for (int i = 0; i < 16; i++) begin
         check("t2_order", (sent_q.size() > 0) ? {24'd0, sent_q.pop_front()} : 32'hFFFF_FFFF, 32'h10 + i);
      end
      check("t2_wr_busy", wr_while_busy, 0);
      wait_uart_idle();

      // 3: single received byte
      acks0 = ack_cnt;
      rx_present(8'h5A, 1'b0);
      check("t3_acks", ack_cnt - acks0, 1);
      bus_read(ADDR_STATUS, rd);
      check("t3_status", rd, 32'h0000_0105);
      bus_read(ADDR_DATA, rd);
      check("t3_read1", rd, 32'h0000_015A);
      bus_read(ADDR_DATA, rd);
      check("t3_read2", rd, 32'h0000_0000);

      // 4: RX overrun
      acks0 = ack_cnt;
      for (int i = 0; i < 17; i++) rx_present(8'(8'h80 + i), 1'b0);
      check("t4_acks", ack_cnt - acks0, 17);
      bus_read(ADDR_STATUS, rd);
      check("t4_status", rd, 32'h0000_1027);
      for (int i = 0; i < 16; i++) begin
         bus_read(ADDR_DATA, rd);
         check("t4_read", rd, 32'h180 + i);
      end
      bus_write(ADDR_STATUS, 8'h20);
      bus_read(ADDR_STATUS, rd);
      check("t4_status_clr", rd, 32'h0000_0004);

      // 5: framing error, then reset in the middle of a TX drain
      acks0 = ack_cnt;
      rx_present(8'h33, 1'b1);
      check("t5_acks", ack_cnt - acks0, 1);
      bus_read(ADDR_STATUS, rd);
      check("t5_status_ferr", rd, 32'h0000_0044);
      bus_read(ADDR_DATA, rd);
      check("t5_no_push", rd, 32'h0000_0000);
      bus_write(ADDR_DATA, 8'h61);
      bus_write(ADDR_DATA, 8'h62);
      bus_write(ADDR_DATA, 8'h63);
      wait_sent(1, 100);
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_rst_tx_wr", {31'd0, tx_wr}, 32'd0);
      resetn = 1'b1;
      bus_read(ADDR_STATUS, rd);
      check("t5_status_after_rst", rd, 32'h0000_0004);
      repeat (BUSY_CYC + 100) @(negedge clk);
      check("t5_sent_after_rst", sent_q.size(), 1);
      check("t5_inflight_byte", (sent_q.size() > 0) ? {24'd0, sent_q.pop_front()} : 32'hFFFF_FFFF, 32'h61);
      sent_q.delete();
      wait_uart_idle();

      // Randomized traffic against the queue reference
      rand_tx = 0;
      ferr_m  = 1'b0;
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 3))
            0: begin
               if (rand_tx < 10) begin
                  b = 8'($urandom);
                  bus_write(ADDR_DATA, b);
                  tx_exp.push_back(b);
                  rand_tx++;
               end
            end
            1: begin
               if (rx_m.size() < 16) begin
                  b = 8'($urandom);
                  e = ($urandom_range(0, 7) == 0);
                  rx_present(b, e);
                  if (e) ferr_m = 1'b1;
                  else   rx_m.push_back(b);
               end
            end
            2: begin
               bus_read(ADDR_DATA, rd);
               exp_v = (rx_m.size() > 0) ? {23'd0, 1'b1, rx_m.pop_front()} : 32'd0;
               check("rnd_data", rd, exp_v);
            end
            default: begin
               bus_read(ADDR_STATUS, rd);
               exp_v = (32'(rx_m.size()) << 8) | (32'(ferr_m) << 6) |
                       (32'(rx_m.size() == 16) << 1) | 32'(rx_m.size() != 0);
               check("rnd_status", rd & 32'h0000_FF73, exp_v);
            end
         endcase
      end
      while (rx_m.size() > 0) begin
         bus_read(ADDR_DATA, rd);
         check("rnd_drain", rd, {23'd0, 1'b1, rx_m.pop_front()});
      end
      wait_sent(tx_exp.size(), (tx_exp.size() + 1) * (BUSY_CYC + 20));
      while (tx_exp.size() > 0) begin
         check("rnd_tx_order", (sent_q.size() > 0) ? {24'd0, sent_q.pop_front()} : 32'hFFFF_FFFF,
               {24'd0, tx_exp.pop_front()});
      end
      check("rnd_wr_busy", wr_while_busy, 0);
      wait_uart_idle();
      bus_write(ADDR_STATUS, 8'h70);

      // 6: interrupt behaviour
`ifdef UART_FIFO_BRIDGE_IRQ_EN
      bus_write(ADDR_CTRL, 8'h01);
      bus_read(ADDR_CTRL, rd);
      check("t6_ctrl_rb", rd, 32'h0000_0001);
      repeat (2) @(negedge clk);
      check("t6_irq_idle", {31'd0, irq}, 32'd0);
      rx_present(8'hC3, 1'b0);
      repeat (2) @(negedge clk);
      check("t6_irq_rise", {31'd0, irq}, 32'd1);
      bus_read(ADDR_DATA, rd);
      check("t6_pop", rd, 32'h0000_01C3);
      for (int i = 0; i < 2 && irq; i++) @(negedge clk);
      check("t6_irq_fall", {31'd0, irq}, 32'd0);
      bus_write(ADDR_CTRL, 8'h02);
      repeat (2) @(negedge clk);
      check("t6_irq_txe", {31'd0, irq}, 32'd1);
      bus_write(ADDR_CTRL, 8'h00);
      repeat (2) @(negedge clk);
      check("t6_irq_off", {31'd0, irq}, 32'd0);
`else
      bus_write(ADDR_CTRL, 8'h03);
      bus_read(ADDR_CTRL, rd);
      check("t6_ctrl_absent", rd, 32'h0000_0000);
      rx_present(8'hC3, 1'b0);
      repeat (2) @(negedge clk);
      check("t6_irq_tied", {31'd0, irq}, 32'd0);
      bus_read(ADDR_DATA, rd);
      check("t6_pop", rd, 32'h0000_01C3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
